// File: rtl/jb_prach_oran_pkg.sv
// Shared word formats, FSM states and sub-frame constants for the PRACH
// request scheduler and the send-stage queues.
package jb_prach_oran_pkg;

  localparam int PRACH_NUM_SF = 10;
  localparam int PRACH_SF_W   = 4;

  typedef struct packed {
    logic [3:0]            ss;
    logic [7:0]            cc;
    logic [PRACH_SF_W-1:0] sf;
    logic [11:0]           section_id;
  } cplane_fifo_words_t;

  typedef struct packed {
    logic [3:0]            ss;
    logic [7:0]            cc;
    logic [PRACH_SF_W-1:0] sf;
    logic [11:0]           section_id;
  } prach_fifo_words_t;

  typedef struct packed {
    logic [PRACH_SF_W-1:0] sub_frame;
    logic [9:0]            address;
    logic [1:0]            antenna;
  } prach_fft_tuser_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    SEND  = 2'd2,
    WAIT1 = 2'd3
  } send_states_t;

  function automatic logic sf_in_range(input logic [PRACH_SF_W-1:0] sf);
    return int'(sf) < PRACH_NUM_SF;
  endfunction

  function automatic prach_fifo_words_t to_prach_word(input cplane_fifo_words_t w);
    prach_fifo_words_t r;
    r.ss         = w.ss;
    r.cc         = w.cc;
    r.sf         = w.sf;
    r.section_id = w.section_id;
    return r;
  endfunction

endpackage

// File: rtl/jb_prach_req_sched_if.sv
// C-plane input, FFT output tap and send-stage request channel of the
// PRACH request scheduler.
interface jb_prach_req_sched_if
  import jb_prach_oran_pkg::*;
;
  logic               cp_valid;
  logic               cp_ready;
  cplane_fifo_words_t cp_word;
  logic               fft_tvalid;
  prach_fft_tuser_t   fft_tuser;
  logic               req_valid;
  logic               req_ready;
  prach_fifo_words_t  req_word;

  modport master (
    output cp_valid, cp_word, fft_tvalid, fft_tuser, req_ready,
    input  cp_ready, req_valid, req_word
  );

  modport slave (
    input  cp_valid, cp_word, fft_tvalid, fft_tuser, req_ready,
    output cp_ready, req_valid, req_word
  );
endinterface

// File: rtl/jb_prach_sync_fifo.sv
// Single-clock FIFO with registered level; the head word is visible
// combinationally on rd_data_o while not empty.
module jb_prach_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i & ~full_o;
  assign do_rd = rd_en_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/jb_prach_req_sched.sv
// PRACH request scheduler: queues C-plane sections, tracks per-sub-frame FFT
// completion across antennas, and issues one request per completed section.
module jb_prach_req_sched
  import jb_prach_oran_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int NUM_ANT       = 4,
  parameter int TIMEOUT_CYC   = 65536,
  parameter int FFT_LAST_ADDR = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  jb_prach_req_sched_if.slave           sched_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_bad_sf_o,
  output logic                          err_timeout_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int WW    = $bits(cplane_fifo_words_t);

  logic                                    ready_en_q;
  logic                                    err_bad_sf_q;
  logic [PRACH_NUM_SF-1:0][NUM_ANT-1:0]    bmp_q, bmp_d;
  send_states_t                            state_q, state_d;
  prach_fifo_words_t                       req_word_q, req_word_d;
  logic                                    req_valid_q, req_valid_d;
  logic [TMR_W-1:0]                        timer_q, timer_d;
  logic                                    chk_vld_q, chk_vld_d;

  logic               cp_acc, cp_sf_ok, push, pop;
  logic               fifo_full, fifo_empty;
  logic [WW-1:0]      head_raw;
  cplane_fifo_words_t head_word;
  logic               fft_ok, row_full;

  // cp_ready stays low until the first edge after reset release.
  assign sched_if.cp_ready = ready_en_q & ~fifo_full;
  assign cp_acc            = sched_if.cp_valid & sched_if.cp_ready;
  assign cp_sf_ok          = sf_in_range(sched_if.cp_word.sf);
  assign push              = cp_acc & cp_sf_ok;
  assign head_word         = head_raw;

  jb_prach_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_data_i (sched_if.cp_word),
    .rd_en_i   (pop),
    .rd_data_o (head_raw),
    .level_o   (fifo_level_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign fft_ok = sched_if.fft_tvalid & sf_in_range(sched_if.fft_tuser.sub_frame);

  always_comb begin
    bmp_d = bmp_q;
    if (fft_ok) begin
      if ((int'(sched_if.fft_tuser.address) == FFT_LAST_ADDR) &&
          (int'(sched_if.fft_tuser.antenna) < NUM_ANT)) begin
        bmp_d[sched_if.fft_tuser.sub_frame][sched_if.fft_tuser.antenna] = 1'b1;
      end else if ((sched_if.fft_tuser.address == '0) &&
                   (sched_if.fft_tuser.antenna == '0)) begin
        bmp_d[sched_if.fft_tuser.sub_frame] = '0;
      end
    end
  end

  assign row_full = &bmp_q[req_word_q.sf];

  // The first STAGE cycle only settles the staged word; the row is judged
  // from the second cycle on, once chk_vld_q is set.
  always_comb begin
    state_d     = state_q;
    req_word_d  = req_word_q;
    req_valid_d = req_valid_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = STAGE;
          req_word_d = to_prach_word(head_word);
          timer_d    = '0;
        end
      end
      STAGE: begin
        if (chk_vld_q && row_full) begin
          pop         = 1'b1;
          req_valid_d = 1'b1;
          state_d     = SEND;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          pop     = 1'b1;
          state_d = WAIT1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SEND: begin
        if (req_valid_q && sched_if.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WAIT1:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    chk_vld_d = (state_q == STAGE) && (state_d == STAGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q   <= 1'b0;
      err_bad_sf_q <= 1'b0;
      bmp_q        <= '0;
      state_q      <= IDLE;
      req_word_q   <= '0;
      req_valid_q  <= 1'b0;
      timer_q      <= '0;
      chk_vld_q    <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      err_bad_sf_q <= cp_acc & ~cp_sf_ok;
      bmp_q        <= bmp_d;
      state_q      <= state_d;
      req_word_q   <= req_word_d;
      req_valid_q  <= req_valid_d;
      timer_q      <= timer_d;
      chk_vld_q    <= chk_vld_d;
    end
  end

  assign sched_if.req_valid = req_valid_q;
  assign sched_if.req_word  = req_word_q;
  assign err_bad_sf_o       = err_bad_sf_q;
  assign err_timeout_o      = (state_q == WAIT1);

endmodule

// File: tb/tb_jb_prach_req_sched.sv
// Directed bench for jb_prach_req_sched: vector table for single sections
// plus hand-written multi-cycle sequences.
module tb_jb_prach_req_sched;
  import jb_prach_oran_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jb_prach_req_sched_if ifc ();
  logic [4:0] fifo_level;
  logic       err_bad_sf;
  logic       err_timeout;

  jb_prach_req_sched #(
    .FIFO_DEPTH    (16),
    .NUM_ANT       (4),
    .TIMEOUT_CYC   (64),
    .FFT_LAST_ADDR (1023)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sched_if      (ifc.slave),
    .fifo_level_o  (fifo_level),
    .err_bad_sf_o  (err_bad_sf),
    .err_timeout_o (err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [27:0] word;
    bit          exp_bad;
    int          exp_lat;
    logic [27:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] mk(input logic [3:0] ss, input logic [7:0] cc,
                                     input logic [3:0] sf, input logic [11:0] id);
    return {ss, cc, sf, id};
  endfunction

  task automatic beat(input int sf, input int addr, input int ant);
    ifc.fft_tvalid           = 1'b1;
    ifc.fft_tuser.sub_frame  = 4'(sf);
    ifc.fft_tuser.address    = 10'(addr);
    ifc.fft_tuser.antenna    = 2'(ant);
    step();
    ifc.fft_tvalid = 1'b0;
  endtask

  task automatic fill_row(input int sf, input int nant);
    beat(sf, 0, 0);
    for (int a = 0; a < nant; a++) beat(sf, 1023, a);
  endtask

  task automatic push(input logic [27:0] w);
    ifc.cp_valid = 1'b1;
    ifc.cp_word  = w;
    step();
    ifc.cp_valid = 1'b0;
  endtask

  task automatic wait_req(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (ifc.req_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept();
    ifc.req_ready = 1'b1;
    step();
    ifc.req_ready = 1'b0;
  endtask

  task automatic quiet(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (ifc.req_valid !== 1'b0) seen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, stable, k;
    logic [27:0] w;

    vecs[0] = '{word: 28'h1220001, exp_bad: 1'b0, exp_lat: 3, exp_word: 28'h1220001};
    vecs[1] = '{word: 28'hFFF9FFF, exp_bad: 1'b0, exp_lat: 3, exp_word: 28'hFFF9FFF};
    vecs[2] = '{word: 28'h000A0AB, exp_bad: 1'b1, exp_lat: 0, exp_word: 28'h0};
    vecs[3] = '{word: 28'h3105123, exp_bad: 1'b0, exp_lat: 3, exp_word: 28'h3105123};
    vecs[4] = '{word: 28'h001F000, exp_bad: 1'b1, exp_lat: 0, exp_word: 28'h0};
    vecs[5] = '{word: 28'h6403800, exp_bad: 1'b0, exp_lat: 3, exp_word: 28'h6403800};

    ifc.cp_valid   = 1'b0;
    ifc.cp_word    = '0;
    ifc.fft_tvalid = 1'b0;
    ifc.fft_tuser  = '0;
    ifc.req_ready  = 1'b0;

    // Reset state
    #2;
    chk("rst_cp_ready", 32'(ifc.cp_ready), 0);
    chk("rst_req_valid", 32'(ifc.req_valid), 0);
    chk("rst_req_word", 32'(ifc.req_word), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_err", {30'd0, err_bad_sf, err_timeout}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cp_ready_before_edge", 32'(ifc.cp_ready), 0);
    step();
    chk("cp_ready_after_edge", 32'(ifc.cp_ready), 1);
    chk("idle_req_valid", 32'(ifc.req_valid), 0);

    // Full FFT epoch for sf=3, then one section
    for (int a = 0; a < 4; a++)
      for (int addr = 0; addr < 1024; addr++) beat(3, addr, a);
    w = mk(4'd5, 8'd1, 4'd3, 12'h012);
    push(w);
    chk("row3_level_after_push", 32'(fifo_level), 1);
    wait_req(20, lat);
    chk("row3_latency", 32'(lat), 3);
    chk("row3_req_word", 32'(ifc.req_word), 32'h5013012);
    chk("row3_level_popped", 32'(fifo_level), 0);
    accept();
    chk("row3_valid_dropped", 32'(ifc.req_valid), 0);
    quiet(8, seen);
    chk("row3_no_reissue", 32'(seen), 0);

    // Back-pressure: held 20 cycles, single accept
    w = mk(4'd2, 8'd7, 4'd3, 12'h345);
    push(w);
    wait_req(20, lat);
    chk("bp_latency", 32'(lat), 3);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifc.req_valid !== 1'b1 || ifc.req_word !== 28'h2073345) stable = 0;
    end
    chk("bp_stable", 32'(stable), 1);
    accept();
    chk("bp_valid_dropped", 32'(ifc.req_valid), 0);
    quiet(8, seen);
    chk("bp_single_accept", 32'(seen), 0);

    // Rows 0..9 complete except row 7 (antennas 0..2 only)
    for (int r = 0; r < 10; r++) fill_row(r, (r == 7) ? 3 : 4);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word);
      chk($sformatf("vec%0d_err_bad_sf", i), 32'(err_bad_sf), 32'(vecs[i].exp_bad));
      if (vecs[i].exp_bad) begin
        chk($sformatf("vec%0d_level", i), 32'(fifo_level), 0);
        step();
        chk($sformatf("vec%0d_bad_pulse_end", i), 32'(err_bad_sf), 0);
        quiet(6, seen);
        chk($sformatf("vec%0d_no_req", i), 32'(seen), 0);
      end else begin
        wait_req(20, lat);
        chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        chk($sformatf("vec%0d_req_word", i), 32'(ifc.req_word), 32'(vecs[i].exp_word));
        accept();
        chk($sformatf("vec%0d_valid_dropped", i), 32'(ifc.req_valid), 0);
      end
    end

    // Timeout on incomplete row 7
    push(mk(4'd1, 8'd2, 4'd7, 12'h077));
    chk("to_level_queued", 32'(fifo_level), 1);
    lat = -1;
    seen = 0;
    for (k = 1; k <= 100; k++) begin
      step();
      if (ifc.req_valid !== 1'b0) seen++;
      if (err_timeout === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("to_cycles_from_push", 32'(lat), 65);
    chk("to_no_req", 32'(seen), 0);
    chk("to_level_popped", 32'(fifo_level), 0);
    step();
    chk("to_pulse_end", 32'(err_timeout), 0);

    // Fill the FIFO while row 7 is still incomplete
    stable = 1;
    for (int i = 0; i < 16; i++) begin
      if (ifc.cp_ready !== 1'b1) stable = 0;
      push(mk(4'(i), 8'(96 + i), 4'd7, 12'(256 + i)));
    end
    chk("full_ready_during_fill", 32'(stable), 1);
    chk("full_level", 32'(fifo_level), 16);
    chk("full_cp_ready_low", 32'(ifc.cp_ready), 0);
    push(mk(4'hE, 8'hEE, 4'd7, 12'hEEE));
    chk("full_17th_rejected", 32'(fifo_level), 16);
    beat(7, 1023, 3);
    ifc.req_ready = 1'b1;
    stable = 1;
    for (int i = 0; i < 16; i++) begin
      wait_req(10, lat);
      if (lat < 0) stable = 0;
      chk($sformatf("drain%0d_word", i), 32'(ifc.req_word),
          32'(mk(4'(i), 8'(96 + i), 4'd7, 12'(256 + i))));
      step();
    end
    ifc.req_ready = 1'b0;
    chk("drain_all_found", 32'(stable), 1);
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_cp_ready", 32'(ifc.cp_ready), 1);
    quiet(8, seen);
    chk("drain_no_17th", 32'(seen), 0);

    // Epoch clear of row 3 holds the next sf=3 section; bad sf alongside
    beat(3, 0, 0);
    push(mk(4'd4, 8'd4, 4'd3, 12'h033));
    quiet(12, seen);
    chk("epoch_waits", 32'(seen), 0);
    push(mk(4'd0, 8'd0, 4'd12, 12'h0));
    chk("badsf_pulse", 32'(err_bad_sf), 1);
    chk("badsf_level", 32'(fifo_level), 1);
    step();
    chk("badsf_pulse_end", 32'(err_bad_sf), 0);
    for (int a = 0; a < 4; a++) beat(3, 1023, a);
    wait_req(10, lat);
    chk("epoch_served", 32'(lat > 0), 1);
    chk("epoch_req_word", 32'(ifc.req_word), 32'h4043033);
    accept();

    // Reset in the middle of a pending request
    push(mk(4'd7, 8'd7, 4'd5, 12'h555));
    push(mk(4'd8, 8'd8, 4'd5, 12'h888));
    wait_req(10, lat);
    chk("mid_req_seen", 32'(ifc.req_valid), 1);
    chk("mid_level_before", 32'(fifo_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(ifc.req_valid), 0);
    chk("mid_rst_req_word", 32'(ifc.req_word), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_cp_ready", 32'(ifc.cp_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_cp_ready_back", 32'(ifc.cp_ready), 1);
    quiet(8, seen);
    chk("mid_flushed", 32'(seen), 0);
    push(mk(4'd9, 8'd9, 4'd5, 12'h999));
    lat = -1;
    seen = 0;
    for (k = 1; k <= 100; k++) begin
      step();
      if (ifc.req_valid !== 1'b0) seen++;
      if (err_timeout === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("mid_bitmap_cleared_no_req", 32'(seen), 0);
    chk("mid_bitmap_cleared_timeout", 32'(lat), 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
